prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Receive-side PRBS checker, one stage downstream of the serializer output (dout_p/dout_n after the receiver slicer).
- Takes one sliced bit per valid cycle, self-synchronizes to a PRBS7, PRBS15 or PRBS31 stream, then free-runs a local generator.
- Counts bit errors, including errors created deliberately through the transmit-side inj_error, and reports lock status.
- Used for loopback BER measurement of the analog link.

Parameters:
- ERR_CNT_W, 16: error counter width; the counter saturates.
- LOCK_CNT, 64: consecutive matching bits required in HUNT to declare lock.
- WIN, 128: loss-of-lock observation window, in valid bits.
- UNLOCK_ERR, 8: errors within one window that force loss of lock.

Ports:
- clk  input  1  bit clock; all logic on the rising edge.
- rst  input  1  synchronous active-high reset.
- din  input  1  received serial bit.
- din_valid  input  1  qualifies din; when low, no state, counter or register changes occur.
- prbs_sel  input  2  polynomial select:
  - 00 = PRBS7, x^7+x^6+1
  - 01 = PRBS15, x^15+x^14+1
  - 10 = PRBS31, x^31+x^28+1
  - 11 = treated as PRBS7
- invert  input  1  when 1, din is inverted before checking.
- clr_cnt  input  1  synchronous clear of err_cnt.
- locked  output  1  high while in LOCKED.
- err_pulse  output  1  one-cycle pulse for each errored bit while LOCKED.
- err_cnt  output  ERR_CNT_W  saturating error count.

Behaviour:
- Reset (rst=1 at an edge):
  - state=SEED, sr[30:0]=0, all internal counters 0.
  - locked=0, err_pulse=0, err_cnt=0.
  - The registered copy of prbs_sel is loaded.
- Datapath:
  - d = din ^ invert.
  - Predicted bit p:
    - PRBS7: sr[6]^sr[5]
    - PRBS15: sr[14]^sr[13]
    - PRBS31: sr[30]^sr[27]
  - mismatch = d ^ p.
- Shift register update (valid cycles only):
  - SEED/HUNT: sr <= {sr[29:0], d}, i.e. self-synchronizing from received data.
  - LOCKED: sr <= {sr[29:0], p}, i.e. free-running, so errors do not propagate.
- State machine (transitions evaluated on valid cycles only):
  - SEED:
    - Count valid bits.
    - After ORDER bits (7/15/31 for the selected polynomial), go to HUNT with match_cnt=0.
  - HUNT:
    - Mismatch: match_cnt <= 0.
    - Match: match_cnt increments.
    - When the LOCK_CNT-th consecutive match is seen, go to LOCKED. locked goes high on the following edge.
    - No error counting in this state.
  - LOCKED:
    - Mismatch: err_pulse=1 on the next cycle, and err_cnt increments unless it is all-ones.
    - win_cnt counts valid bits 0..WIN-1; win_err counts mismatches.
    - After bit WIN-1 is processed, both counters reset to 0.
    - If win_err including the current bit reaches UNLOCK_ERR, go to SEED. locked falls on the following edge. That bit is still counted in err_cnt.
- Latency: a bit at edge n produces err_pulse and the err_cnt update at edge n+1 (registered outputs). err_pulse is 0 on all other cycles, including invalid cycles.
- err_cnt:
  - Saturates at 2^ERR_CNT_W-1.
  - Holds its value across loss of lock and relock; only rst and clr_cnt clear it.
  - clr_cnt coinciding with an error: the clear wins and err_cnt=0. err_pulse still fires.
- prbs_sel change:
  - A prbs_sel value differing from the registered copy (checked every cycle, regardless of din_valid) forces SEED on the next edge.
  - The new value is registered, and locked falls.
  - err_cnt is untouched.
- Reset mid-operation: same as power-up reset regardless of state. rst takes priority over all other inputs.

Test Plan:
1. rst, then a clean PRBS7 stream with din_valid=1 continuously.
   - locked rises after exactly 7+64=71 valid bits.
   - err_cnt=0 after 1000 further bits.
2. Locked PRBS7, flip one bit.
   - err_pulse high for exactly one cycle, one cycle after the flipped bit.
   - err_cnt=1; locked stays 1.
   - The bits following the flip produce no further errors.
3. Locked stream, 8 flips within 128 bits.
   - locked falls the cycle after the 8th error; err_cnt=8.
   - The checker relocks 71 bits after the clean stream resumes, and err_cnt stays 8.
4. Inverted PRBS7 stream.
   - invert=1: lock in 71 bits.
   - invert=0: never locks over 2000 bits, and err_cnt stays 0.
5. Saturation and clear: ERR_CNT_W=4, UNLOCK_ERR=200, 20 flips.
   - err_cnt holds at 15.
   - clr_cnt asserted in the same cycle as an error: err_cnt=0 next cycle, with err_pulse=1.
6. Selection change and valid gaps.
   - Switch prbs_sel 00→01 while locked: locked falls next cycle, and the checker relocks after 15+64 PRBS15 bits.
   - Repeat PRBS31 with din_valid toggling 1010...: lock after 31+64 valid bits.

Source files
------------

// File: rtl/prbs_checker.sv
// Receive-side PRBS7/15/31 checker: self-synchronizes, then free-runs.
// Counts bit errors while locked and tracks loss of lock per window.
module prbs_checker #(
  parameter int ERR_CNT_W  = 16,
  parameter int LOCK_CNT   = 64,
  parameter int WIN        = 128,
  parameter int UNLOCK_ERR = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din,
  input  logic                 din_valid,
  input  logic [1:0]           prbs_sel,
  input  logic                 invert,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int EW = $clog2(UNLOCK_ERR + 1);

  typedef enum logic [1:0] {
    SEED,
    HUNT,
    LOCKED
  } state_t;

  state_t               state, state_n;
  logic [30:0]          sr, sr_n;
  logic [1:0]           sel_q;
  logic [4:0]           seed_cnt, seed_n;
  logic [MW-1:0]        match_cnt, match_n;
  logic [WW-1:0]        win_cnt, win_n;
  logic [EW-1:0]        werr_cnt, werr_n;
  logic [EW-1:0]        werr_tot;
  logic [ERR_CNT_W-1:0] cnt_n;
  logic                 pulse_q, pulse_n;
  logic                 d, p, mism, sel_chg;
  logic [4:0]           order;

  // Received bit, predicted bit and polynomial order for the selected PRBS
  always_comb begin
    d = din ^ invert;
    case (sel_q)
      2'b01: begin
        p     = sr[14] ^ sr[13];
        order = 5'd15;
      end
      2'b10: begin
        p     = sr[30] ^ sr[27];
        order = 5'd31;
      end
      default: begin
        p     = sr[6] ^ sr[5];
        order = 5'd7;
      end
    endcase
    mism    = d ^ p;
    sel_chg = (prbs_sel != sel_q);
  end

  // Next-state, shift register, counters and error reporting
  always_comb begin
    state_n  = state;
    sr_n     = sr;
    seed_n   = seed_cnt;
    match_n  = match_cnt;
    win_n    = win_cnt;
    werr_n   = werr_cnt;
    cnt_n    = err_cnt;
    pulse_n  = 1'b0;
    werr_tot = werr_cnt + EW'(mism);
    if (sel_chg) begin
      state_n = SEED;
      seed_n  = '0;
      match_n = '0;
      win_n   = '0;
      werr_n  = '0;
    end else if (din_valid) begin
      case (state)
        SEED: begin
          sr_n = {sr[29:0], d};
          if (seed_cnt == order - 5'd1) begin
            state_n = HUNT;
            seed_n  = '0;
            match_n = '0;
          end else begin
            seed_n = seed_cnt + 5'd1;
          end
        end
        HUNT: begin
          sr_n = {sr[29:0], d};
          if (mism) begin
            match_n = '0;
          end else if (match_cnt == MW'(LOCK_CNT - 1)) begin
            state_n = LOCKED;
            match_n = '0;
            win_n   = '0;
            werr_n  = '0;
          end else begin
            match_n = match_cnt + MW'(1);
          end
        end
        LOCKED: begin
          sr_n    = {sr[29:0], p};
          pulse_n = mism;
          if (mism && (err_cnt != '1)) begin
            cnt_n = err_cnt + ERR_CNT_W'(1);
          end
          if (werr_tot >= EW'(UNLOCK_ERR)) begin
            state_n = SEED;
            seed_n  = '0;
            win_n   = '0;
            werr_n  = '0;
          end else if (win_cnt == WW'(WIN - 1)) begin
            win_n  = '0;
            werr_n = '0;
          end else begin
            win_n  = win_cnt + WW'(1);
            werr_n = werr_tot;
          end
        end
        default: begin
          state_n = SEED;
          seed_n  = '0;
        end
      endcase
    end
    if (clr_cnt) begin
      cnt_n = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEED;
      sr        <= '0;
      sel_q     <= prbs_sel;
      seed_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      werr_cnt  <= '0;
      err_cnt   <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state     <= state_n;
      sr        <= sr_n;
      sel_q     <= prbs_sel;
      seed_cnt  <= seed_n;
      match_cnt <= match_n;
      win_cnt   <= win_n;
      werr_cnt  <= werr_n;
      err_cnt   <= cnt_n;
      pulse_q   <= pulse_n;
    end
  end

  assign locked    = (state == LOCKED);
  assign err_pulse = pulse_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: lock, errors, unlock, invert,
// saturation/clear, polynomial switch and valid gaps.
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic [1:0]  prbs_sel = 2'b00;
  logic        invert = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_cnt;
  logic        locked_s, err_pulse_s;
  logic [3:0]  err_cnt_s;

  logic [30:0] g;
  logic [1:0]  gsel;
  logic        inv_tx;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .prbs_sel(prbs_sel), .invert(invert), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  prbs_checker #(.ERR_CNT_W(4), .UNLOCK_ERR(200)) dut_s (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .prbs_sel(prbs_sel), .invert(invert), .clr_cnt(clr_cnt),
    .locked(locked_s), .err_pulse(err_pulse_s), .err_cnt(err_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference transmit generator, always advanced with the true bit
  task automatic next_bit(output logic b);
    case (gsel)
      2'b01:   b = g[14] ^ g[13];
      2'b10:   b = g[30] ^ g[27];
      default: b = g[6] ^ g[5];
    endcase
    g = {g[29:0], b};
  endtask

  task automatic cyc(input logic dv, input logic v, input logic c);
    din = dv;
    din_valid = v;
    clr_cnt = c;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clr_cnt = 1'b0;
  endtask

  task automatic tx(input logic flip, input logic c);
    logic b;
    next_bit(b);
    cyc(b ^ flip ^ inv_tx, 1'b1, c);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tx(1'b0, 1'b0);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int np;
    logic seen;
    g = 31'h5A5A5A5;
    gsel = 2'b00;
    inv_tx = 1'b0;

    // 1: reset state, clean PRBS7 lock, long clean run
    do_rst();
    check("rst_locked", locked, 0);
    check("rst_pulse", err_pulse, 0);
    check("rst_cnt", err_cnt, 0);
    run(70);
    check("lock7_70", locked, 0);
    run(1);
    check("lock7_71", locked, 1);
    np = 0;
    for (int i = 0; i < 1000; i++) begin
      tx(1'b0, 1'b0);
      if (err_pulse) np++;
    end
    check("clean_cnt", err_cnt, 0);
    check("clean_pulses", np, 0);
    check("clean_locked", locked, 1);

    // 2: single flipped bit
    tx(1'b1, 1'b0);
    check("flip_pulse", err_pulse, 1);
    check("flip_cnt", err_cnt, 1);
    tx(1'b0, 1'b0);
    check("flip_pulse_end", err_pulse, 0);
    check("flip_locked", locked, 1);
    np = 0;
    for (int i = 0; i < 200; i++) begin
      tx(1'b0, 1'b0);
      if (err_pulse) np++;
    end
    check("flip_no_prop", np, 0);
    check("flip_cnt_hold", err_cnt, 1);

    // 3: eight errors in one window -> unlock, then relock
    do_rst();
    check("rst_mid_cnt", err_cnt, 0);
    run(71);
    check("lock3", locked, 1);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) check("pre8_locked", locked, 1);
      tx(1'b1, 1'b0);
      if (k < 7) run(9);
    end
    check("unlock_locked", locked, 0);
    check("unlock_cnt", err_cnt, 8);
    run(70);
    check("relock_70", locked, 0);
    run(1);
    check("relock_71", locked, 1);
    check("relock_cnt", err_cnt, 8);

    // 4: inverted stream
    inv_tx = 1'b1;
    invert = 1'b1;
    do_rst();
    run(70);
    check("inv_70", locked, 0);
    run(1);
    check("inv_71", locked, 1);
    invert = 1'b0;
    do_rst();
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      tx(1'b0, 1'b0);
      if (locked) seen = 1'b1;
    end
    check("noinv_lock", seen, 0);
    check("noinv_cnt", err_cnt, 0);
    inv_tx = 1'b0;

    // 5: saturation and clear on narrow counter
    do_rst();
    run(71);
    check("sat_lock", locked_s, 1);
    for (int k = 0; k < 20; k++) begin
      tx(1'b1, 1'b0);
      run(4);
    end
    check("sat_cnt", err_cnt_s, 15);
    check("sat_locked", locked_s, 1);
    tx(1'b1, 1'b1);
    check("clr_cnt", err_cnt_s, 0);
    check("clr_pulse", err_pulse_s, 1);

    // 6a: PRBS7 -> PRBS15 switch while locked
    do_rst();
    run(71);
    tx(1'b1, 1'b0);
    check("sw_pre_cnt", err_cnt, 1);
    check("sw_pre_lock", locked, 1);
    prbs_sel = 2'b01;
    cyc(1'b0, 1'b0, 1'b0);
    check("sw_unlock", locked, 0);
    check("sw_cnt_hold", err_cnt, 1);
    gsel = 2'b01;
    g = 31'h1234567;
    run(78);
    check("lock15_78", locked, 0);
    run(1);
    check("lock15_79", locked, 1);

    // 6b: PRBS31 with alternating valid
    prbs_sel = 2'b10;
    gsel = 2'b10;
    g = 31'h5A5A5A5;
    do_rst();
    for (int i = 0; i < 94; i++) begin
      tx(1'b0, 1'b0);
      cyc(1'($urandom_range(1)), 1'b0, 1'b0);
    end
    check("lock31_94", locked, 0);
    tx(1'b0, 1'b0);
    check("lock31_95", locked, 1);
    cyc(1'($urandom_range(1)), 1'b0, 1'b0);
    check("gap_locked", locked, 1);
    check("gap_pulse", err_pulse, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
